// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: translates the PC into an instruction-memory word index,
// runs a req/ready + rvalid handshake with that memory, and presents the
// fetched word to decode. pc_enable pulses once when decode accepts it.
// A flush redirects the fetch, and a bad PC locks the unit in a sticky fault.
// Optional build macro FETCH_TIMEOUT_EN: this adds a bound on the response wait
// in WAIT/DRAIN. When the bound is reached, the unit faults and sets timeout_err.
// Without the macro, timeout_err is tied low.
module instr_fetch_unit #(
  parameter int             N              = 32,
  parameter logic [N-1:0]   TEXT_BASE      = 'h400000,
  parameter int             DEPTH_LOG2     = 10,
  parameter int             TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          pc_value,
  output logic                  pc_enable,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [N-1:0]          mem_rdata,
  output logic                  instr_valid,
  output logic [N-1:0]          instr_data,
  output logic [N-1:0]          instr_pc,
  input  logic                  instr_ready,
  output logic                  fetch_fault,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } state_t;

  // One past the highest legal word index, widened so the compare cannot wrap.
  localparam logic [N:0] IDX_LIMIT = {{N{1'b0}}, 1'b1} << DEPTH_LOG2;

  state_t       state;
  logic [N-1:0] pc_off;
  logic [N-1:0] pc_idx;
  logic         pc_bad;
  logic         tmo_hit;

  // PC to word-index translation and legality check for the sample taken in IDLE.
  always_comb begin
    pc_off = pc_value - TEXT_BASE;
    pc_idx = pc_off >> 2;
    pc_bad = (pc_value[1:0] != 2'b00) ||
             (pc_value < TEXT_BASE) ||
             ({1'b0, pc_idx} >= IDX_LIMIT);
  end

  // Advance strobe: only for an instruction that decode accepts without a competing flush.
  assign pc_enable = instr_valid & instr_ready & ~flush;

`ifdef FETCH_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCW-1:0] tmo_cnt;
  logic           tmo_stay;

  // A cycle in which WAIT or DRAIN is still waiting and will not leave for another reason.
  always_comb begin
    tmo_stay = ((state == S_WAIT) && !flush && !mem_rvalid) ||
               ((state == S_DRAIN) && !mem_rvalid);
  end

  assign tmo_hit = tmo_stay && (tmo_cnt == TCW'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting. The count restarts on every entry to WAIT or DRAIN,
  // including the WAIT to DRAIN move.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (tmo_stay) begin
      tmo_cnt <= tmo_cnt + TCW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Sticky record that the fault was caused by a missing response.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (tmo_hit) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Fetch sequencer with registered handshake and output state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pc_bad) begin
            state       <= S_FAULT;
            fetch_fault <= 1'b1;
          end else begin
            state    <= S_REQ;
            mem_req  <= 1'b1;
            mem_addr <= pc_idx[DEPTH_LOG2-1:0];
            instr_pc <= pc_value;
          end
        end

        S_REQ: begin
          if (flush) begin
            mem_req <= 1'b0;
            // An accepted request still has a response coming, which must be drained.
            state   <= mem_ready ? S_DRAIN : S_IDLE;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (flush) begin
            state <= mem_rvalid ? S_IDLE : S_DRAIN;
          end else if (mem_rvalid) begin
            instr_data  <= mem_rdata;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end else if (tmo_hit) begin
            state       <= S_FAULT;
            fetch_fault <= 1'b1;
          end
        end

        S_HOLD: begin
          if (flush || instr_ready) begin
            instr_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end

        // Flush changes nothing here: the unit is already discarding and keeps
        // waiting only for the orphaned response.
        S_DRAIN: begin
          if (mem_rvalid) begin
            state <= S_IDLE;
          end else if (tmo_hit) begin
            state       <= S_FAULT;
            fetch_fault <= 1'b1;
          end
        end

        S_FAULT: begin
          state <= S_FAULT;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. The bench keeps a transaction-level model of
// the fetch: it tracks the pending request, the outstanding response and the
// presented instruction. The model is checked every cycle against the DUT.
// Directed scenarios drive the PC, the flush input, decode readiness and a scripted
// memory. Scenarios also pin the model with hand-computed literal values.
module tb_instr_fetch_unit;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          WORDS = 1024;
  localparam int          TMO   = 16;

  logic        clk;
  logic        reset;
  logic [31:0] pc_value;
  logic        pc_enable;
  logic        flush;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_fault;
  logic        timeout_err;

  instr_fetch_unit #(
    .N              (32),
    .TEXT_BASE      (32'h0040_0000),
    .DEPTH_LOG2     (10),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_value    (pc_value),
    .pc_enable   (pc_enable),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .fetch_fault (fetch_fault),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int pen_count = 0;
  int iv_count  = 0;
  int rq_count  = 0;

  // Scripted memory behaviour.
  int cfg_ready_dly  = 0;
  int cfg_rvalid_dly = 0;
  bit cfg_never      = 0;

  // Model state: one fetch in flight, described by what is pending.
  bit          m_init   = 0;
  bit          m_gap    = 0;  // next edge samples the PC
  bit          m_issue  = 0;  // request being presented to memory
  bit          m_inflight = 0; // request accepted, response owed
  bit          m_orphan = 0;  // owed response is to be discarded
  bit          m_have   = 0;  // instruction presented to decode
  bit          m_fault  = 0;
  bit          m_tmo    = 0;
  bit          m_adv    = 0;  // decode accepted at the last edge
  logic [9:0]  m_addr   = '0;
  logic [31:0] m_pc     = '0;
  logic [31:0] m_data   = '0;
  int          m_wait   = 0;
  int          m_issue_age = 0;

  function automatic logic [31:0] memword(input logic [9:0] a);
    logic [31:0] w;
    w = {22'd0, a};
    return 32'h0050_0093 ^ (w << 12);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model update at each edge from the inputs that were applied during the cycle.
  always @(posedge clk) begin
    longint unsigned p;
    m_adv = 0;
    if (reset) begin
      m_init = 1; m_gap = 1; m_issue = 0; m_inflight = 0; m_orphan = 0;
      m_have = 0; m_fault = 0; m_tmo = 0;
      m_addr = '0; m_pc = '0; m_data = '0; m_wait = 0; m_issue_age = 0;
    end else if (!m_init || m_fault) begin
      // nothing changes
    end else if (m_gap) begin
      m_gap = 0;
      p = pc_value;
      if ((p % 4) != 0 || p < BASE || ((p - BASE) / 4) >= WORDS) begin
        m_fault = 1;
      end else begin
        m_issue = 1;
        m_issue_age = 0;
        m_addr = 10'((p - BASE) / 4);
        m_pc = pc_value;
      end
    end else if (m_issue) begin
      if (flush) begin
        m_issue = 0;
        if (mem_ready) begin m_inflight = 1; m_orphan = 1; m_wait = 0; end
        else m_gap = 1;
      end else if (mem_ready) begin
        m_issue = 0; m_inflight = 1; m_orphan = 0; m_wait = 0;
      end else begin
        m_issue_age++;
      end
    end else if (m_inflight) begin
      if (mem_rvalid) begin
        m_inflight = 0;
        if (m_orphan || flush) m_gap = 1;
        else begin m_have = 1; m_data = mem_rdata; end
      end else if (flush && !m_orphan) begin
        m_orphan = 1;
        m_wait = 0;
      end else begin
        m_wait++;
`ifdef FETCH_TIMEOUT_EN
        if (m_wait == TMO) begin
          m_inflight = 0; m_fault = 1; m_tmo = 1;
        end
`endif
      end
    end else if (m_have) begin
      if (flush || instr_ready) begin
        m_have = 0;
        m_gap = 1;
        m_adv = !flush;
      end
    end
  end

  // Per-cycle comparison of every output against the model, plus event counters.
  always @(negedge clk) begin
    if (m_init) begin
      check("mem_req",     {31'd0, mem_req},     {31'd0, m_issue});
      check("mem_addr",    {22'd0, mem_addr},    {22'd0, m_addr});
      check("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
      check("instr_data",  instr_data,           m_data);
      check("instr_pc",    instr_pc,             m_pc);
      check("pc_enable",   {31'd0, pc_enable},   {31'd0, (m_have && instr_ready && !flush)});
      check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
      check("timeout_err", {31'd0, timeout_err}, {31'd0, m_tmo});
      if (pc_enable === 1'b1)   pen_count++;
      if (instr_valid === 1'b1) iv_count++;
      if (mem_req === 1'b1)     rq_count++;
    end
  end

  // One clock: advance the PC register and drive the scripted memory.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (m_adv) pc_value = pc_value + 32'd4;
    mem_ready  = m_issue && (m_issue_age >= cfg_ready_dly);
    mem_rvalid = m_inflight && !cfg_never && (m_wait >= cfg_rvalid_dly);
    mem_rdata  = m_orphan ? 32'hDEAD_BEEF : memword(m_addr);
    #1;
  endtask

  // Wait (bounded) for the model to reach a phase: 0 issue, 1 waiting, 2 holding, 3 fault.
  task automatic wait_for(input int what, input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      case (what)
        0: hit = m_issue;
        1: hit = m_inflight && !m_orphan;
        2: hit = m_have;
        default: hit = m_fault;
      endcase
      if (!hit) tick();
    end
    if (!hit) check({"reach_", name}, 32'd0, 32'd1);
  endtask

  task automatic do_reset(input logic [31:0] pc);
    reset = 1'b1;
    flush = 1'b0;
    pc_value = pc;
    tick();
    tick();
    check("rst_mem_req",     {31'd0, mem_req},     32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("rst_mem_addr",    {22'd0, mem_addr},    32'd0);
    check("rst_instr_pc",    instr_pc,             32'd0);
    check("rst_instr_data",  instr_data,           32'd0);
    reset = 1'b0;
    pen_count = 0;
    iv_count = 0;
    rq_count = 0;
  endtask

  initial begin
    int t;
    logic [31:0] bad_pcs [3];
    bad_pcs[0] = 32'h0040_0002;
    bad_pcs[1] = 32'h003F_FFFC;
    bad_pcs[2] = 32'h0040_1000;

    reset = 1'b1; flush = 1'b0; instr_ready = 1'b1; pc_value = BASE;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Zero-wait memory, best-case latency and PC advance.
    do_reset(32'h0040_0000);
    wait_for(0, "s1_req");
    t = cyc;
    check("s1_req",  {31'd0, mem_req}, 32'd1);
    check("s1_addr", {22'd0, mem_addr}, 32'd0);
    tick();
    check("s1_wait_no_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("s1_valid_t2", {31'd0, instr_valid}, 32'd1);
    check("s1_data",     instr_data, 32'h0050_0093);
    check("s1_pc",       instr_pc,   32'h0040_0000);
    check("s1_pc_en",    {31'd0, pc_enable}, 32'd1);
    tick();
    check("s1_idle_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("s1_next_t4",  cyc - t, 32'd4);
    check("s1_next_req", {31'd0, mem_req}, 32'd1);
    check("s1_next_addr", {22'd0, mem_addr}, 32'd1);
    check("s1_next_pc",  instr_pc, 32'h0040_0004);
    check("s1_pulses",   pen_count, 32'd1);

    // Slow memory and a stalled decode.
    cfg_ready_dly = 3; cfg_rvalid_dly = 2; instr_ready = 1'b0;
    do_reset(32'h0040_0008);
    wait_for(0, "s2_req");
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      check("s2_req_held",  {31'd0, mem_req}, 32'd1);
      check("s2_addr_held", {22'd0, mem_addr}, 32'd2);
      tick();
    end
    wait_for(2, "s2_hold");
    check("s2_latency", cyc - t, 32'd7);
    for (int i = 0; i < 4; i++) begin
      check("s2_stall_no_en", {31'd0, pc_enable}, 32'd0);
      check("s2_stall_valid", {31'd0, instr_valid}, 32'd1);
      tick();
    end
    instr_ready = 1'b1;
    #1;
    check("s2_accept_en", {31'd0, pc_enable}, 32'd1);
    check("s2_data", instr_data, 32'h0050_2093);
    tick();
    check("s2_after_valid", {31'd0, instr_valid}, 32'd0);
    check("s2_pulses", pen_count, 32'd1);

    // Flush while waiting; the late response is discarded.
    cfg_ready_dly = 0; cfg_rvalid_dly = 2;
    do_reset(32'h0040_0000);
    wait_for(1, "s3_wait");
    flush = 1'b1;
    pc_value = 32'h0040_0040;
    #1;
    tick();
    flush = 1'b0;
    wait_for(0, "s3_refetch");
    check("s3_no_valid", iv_count, 32'd0);
    check("s3_addr", {22'd0, mem_addr}, 32'h10);
    check("s3_pc",   instr_pc, 32'h0040_0040);
    wait_for(2, "s3_hold");
    check("s3_data", instr_data, 32'h0051_0093);

    // Flush while holding, decode ready in the same cycle.
    cfg_ready_dly = 0; cfg_rvalid_dly = 0; instr_ready = 1'b1;
    do_reset(32'h0040_0000);
    wait_for(2, "s4_hold");
    flush = 1'b1;
    pc_value = 32'h0040_0020;
    #1;
    check("s4_en_suppressed", {31'd0, pc_enable}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("s4_valid_drop", {31'd0, instr_valid}, 32'd0);
    wait_for(0, "s4_refetch");
    check("s4_addr", {22'd0, mem_addr}, 32'd8);
    check("s4_pulses", pen_count, 32'd0);

    // Illegal PCs: misaligned, below the text base, beyond the last word.
    foreach (bad_pcs[k]) begin
      do_reset(bad_pcs[k]);
      wait_for(3, "s5_fault");
      check("s5_fault", {31'd0, fetch_fault}, 32'd1);
      flush = 1'b1;
      tick(); tick(); tick();
      flush = 1'b0;
      #1;
      check("s5_fault_sticky", {31'd0, fetch_fault}, 32'd1);
      check("s5_no_req", rq_count, 32'd0);
    end

    // Last legal word.
    do_reset(32'h0040_0FFC);
    wait_for(0, "s5_last");
    check("s5_last_addr", {22'd0, mem_addr}, 32'h3FF);
    check("s5_last_ok",   {31'd0, fetch_fault}, 32'd0);

    // Memory that never answers.
    cfg_never = 1;
    do_reset(32'h0040_0000);
    wait_for(1, "s6_wait");
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    check("s6_not_yet", {31'd0, fetch_fault}, 32'd0);
    tick();
    check("s6_fault",   {31'd0, fetch_fault}, 32'd1);
    check("s6_tmo_err", {31'd0, timeout_err}, 32'd1);
`else
    for (int i = 0; i < 40; i++) tick();
    check("s6_no_fault", {31'd0, fetch_fault}, 32'd0);
    check("s6_no_tmo",   {31'd0, timeout_err}, 32'd0);
    check("s6_no_valid", {31'd0, instr_valid}, 32'd0);
    check("s6_no_req",   {31'd0, mem_req}, 32'd0);
`endif
    cfg_never = 0;
    do_reset(32'h0040_0000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
